// File: rtl/popcount_pkg.sv
// Shared definitions for the ones-count ALU and its downstream frame statistics.
package popcount_pkg;

    // Width of the ALU ones-count output.
    localparam int unsigned SUM_W     = 4;
    // Width of the word the ALU counts ones over.
    localparam int unsigned WORD_W    = 12;
    // Working width of sat_add; accumulators of 1..31 bits are supported.
    localparam int unsigned MAX_ACC_W = 32;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    // Unsigned add clamped to 2^w-1.
    // Bit MAX_ACC_W of the result flags that the true sum exceeded the limit.
    function automatic logic [MAX_ACC_W:0] sat_add(
        input logic [MAX_ACC_W-1:0] a,
        input logic [MAX_ACC_W-1:0] b,
        input int unsigned          w
    );
        logic [MAX_ACC_W:0]   sum_s;
        logic [MAX_ACC_W-1:0] lim_s;
        sum_s = {1'b0, a} + {1'b0, b};
        lim_s = MAX_ACC_W'(((MAX_ACC_W+1)'(1) << w) - (MAX_ACC_W+1)'(1));
        if (sum_s > {1'b0, lim_s}) begin
            sat_add = {1'b1, lim_s};
        end else begin
            sat_add = sum_s;
        end
    endfunction

endpackage

// File: rtl/popcount_frame_accum.sv
// Groups the ALU ones-count stream into frames and reports total, max, min,
// sample count and a saturation flag per frame over a valid/ready handshake.
module popcount_frame_accum
    import popcount_pkg::*;
#(
    parameter int unsigned DATA_W    = SUM_W,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned ACC_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_total,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [7:0]        out_count,
    output logic              out_sat
);

    state_t              state_r;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [ACC_W-1:0]    acc_r;
    logic [7:0]          cnt_r;
    logic [DATA_W-1:0]   max_r;
    logic [DATA_W-1:0]   min_r;
    logic                sat_r;
    logic [ACC_W-1:0]    out_total_r;
    logic [DATA_W-1:0]   out_max_r;
    logic [DATA_W-1:0]   out_min_r;
    logic [7:0]          out_count_r;
    logic                out_sat_r;

    logic                accept_s;
    logic                close_s;
    logic [MAX_ACC_W:0]  add_s;
    logic [ACC_W-1:0]    acc_nxt_s;
    logic [7:0]          cnt_nxt_s;
    logic [DATA_W-1:0]   max_nxt_s;
    logic [DATA_W-1:0]   min_nxt_s;
    logic                sat_nxt_s;

    // Next running statistics including any sample accepted this edge, and the frame-close decision.
    always_comb begin
        accept_s  = 1'b0;
        close_s   = 1'b0;
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
        max_nxt_s = max_r;
        min_nxt_s = min_r;
        sat_nxt_s = sat_r;

        accept_s = in_valid && (state_r == ACCUM);
        add_s    = sat_add(MAX_ACC_W'(acc_r), MAX_ACC_W'(in_sum), ACC_W);

        if (accept_s) begin
            // Upper bits are zero after clamping; folding them in keeps the result safe if ever nonzero.
            acc_nxt_s = (|add_s[MAX_ACC_W-1:ACC_W]) ? {ACC_W{1'b1}} : add_s[ACC_W-1:0];
            sat_nxt_s = sat_r | add_s[MAX_ACC_W];
            cnt_nxt_s = cnt_r + 8'd1;
            max_nxt_s = (in_sum > max_r) ? in_sum : max_r;
            min_nxt_s = (in_sum < min_r) ? in_sum : min_r;
        end else begin
            acc_nxt_s = acc_r;
            sat_nxt_s = sat_r;
            cnt_nxt_s = cnt_r;
            max_nxt_s = max_r;
            min_nxt_s = min_r;
        end

        // A flush on an empty frame closes nothing.
        if (state_r == ACCUM) begin
            close_s = (accept_s && (cnt_nxt_s == 8'(FRAME_LEN))) ||
                      (flush && (cnt_nxt_s != 8'd0));
        end else begin
            close_s = 1'b0;
        end
    end

    // Frame FSM: accumulate in ACCUM, present the registered result in HOLD until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            acc_r       <= {ACC_W{1'b0}};
            cnt_r       <= 8'd0;
            max_r       <= {DATA_W{1'b0}};
            min_r       <= {DATA_W{1'b1}};
            sat_r       <= 1'b0;
            out_total_r <= {ACC_W{1'b0}};
            out_max_r   <= {DATA_W{1'b0}};
            out_min_r   <= {DATA_W{1'b0}};
            out_count_r <= 8'd0;
            out_sat_r   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    acc_r <= acc_nxt_s;
                    cnt_r <= cnt_nxt_s;
                    max_r <= max_nxt_s;
                    min_r <= min_nxt_s;
                    sat_r <= sat_nxt_s;
                    if (close_s) begin
                        out_total_r <= acc_nxt_s;
                        out_max_r   <= max_nxt_s;
                        out_min_r   <= min_nxt_s;
                        out_count_r <= cnt_nxt_s;
                        out_sat_r   <= sat_nxt_s;
                        out_valid_r <= 1'b1;
                        in_ready_r  <= 1'b0;
                        state_r     <= HOLD;
                    end else begin
                        in_ready_r  <= 1'b1;
                    end
                end
                HOLD: begin
                    // Result data stays on out_* after the handshake; only valid drops.
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ACCUM;
                        acc_r       <= {ACC_W{1'b0}};
                        cnt_r       <= 8'd0;
                        max_r       <= {DATA_W{1'b0}};
                        min_r       <= {DATA_W{1'b1}};
                        sat_r       <= 1'b0;
                    end else begin
                        in_ready_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    acc_r       <= {ACC_W{1'b0}};
                    cnt_r       <= 8'd0;
                    max_r       <= {DATA_W{1'b0}};
                    min_r       <= {DATA_W{1'b1}};
                    sat_r       <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_total = out_total_r;
    assign out_max   = out_max_r;
    assign out_min   = out_min_r;
    assign out_count = out_count_r;
    assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_popcount_frame_accum.sv
// Directed self-checking bench for popcount_frame_accum (default widths plus a 6-bit accumulator copy).
module tb_popcount_frame_accum;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1, out_sat;
    logic [3:0] in_sum = 4'd0, out_max, out_min;
    logic [7:0] out_total, out_count;

    logic       in_valid6 = 1'b0, in_ready6, out_valid6, out_ready6 = 1'b1, out_sat6;
    logic [3:0] in_sum6 = 4'd0, out_max6, out_min6;
    logic [5:0] out_total6;
    logic [7:0] out_count6;

    int vectors    = 0;
    int miscompares = 0;

    popcount_frame_accum #(.DATA_W(4), .FRAME_LEN(8), .ACC_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_total(out_total),
        .out_max(out_max), .out_min(out_min), .out_count(out_count), .out_sat(out_sat)
    );

    popcount_frame_accum #(.DATA_W(4), .FRAME_LEN(8), .ACC_W(6)) u_dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid6), .in_ready(in_ready6), .in_sum(in_sum6),
        .flush(1'b0), .out_valid(out_valid6), .out_ready(out_ready6), .out_total(out_total6),
        .out_max(out_max6), .out_min(out_min6), .out_count(out_count6), .out_sat(out_sat6)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample to the 8-bit instance and wait (bounded) until it is taken.
    task automatic push(input logic [3:0] v);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_sum   = v;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL push_timeout: in_ready stayed %0b, expected 1", in_ready);
        end
        tick();
    endtask

    task automatic push6(input logic [3:0] v);
        int n;
        n = 0;
        in_valid6 = 1'b1;
        in_sum6   = v;
        while (!in_ready6 && n < 20) begin
            tick();
            n++;
        end
        vectors++;
        if (n >= 20) begin
            miscompares++;
            $display("FAIL push6_timeout: in_ready stayed %0b, expected 1", in_ready6);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        vectors++; if ({out_total, out_max, out_min, out_count, out_sat} !== 25'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got total=%0d max=%0d min=%0d count=%0d sat=%0b expected all 0",
                     out_total, out_max, out_min, out_count, out_sat);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) push(4'd3);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL full_early_valid: got %0b expected 0", out_valid); end
        push(4'd3);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL full_valid: got %0b expected 1", out_valid); end
        vectors++; if (out_total !== 8'd24) begin miscompares++; $display("FAIL full_total: got %0d expected 24", out_total); end
        vectors++; if (out_max !== 4'd3 || out_min !== 4'd3) begin miscompares++; $display("FAIL full_maxmin: got max=%0d min=%0d expected 3/3", out_max, out_min); end
        vectors++; if (out_count !== 8'd8 || out_sat !== 1'b0) begin miscompares++; $display("FAIL full_count_sat: got count=%0d sat=%0b expected 8/0", out_count, out_sat); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready_hold: got %0b expected 0", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL full_release: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_mixed();
        logic [3:0] samples [8];
        int low;
        samples = '{4'd0, 4'd12, 4'd5, 4'd7, 4'd1, 4'd9, 4'd4, 4'd2};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(samples[i]);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mixed_valid: got %0b expected 1", out_valid); end
        vectors++; if (out_total !== 8'd40) begin miscompares++; $display("FAIL mixed_total: got %0d expected 40", out_total); end
        vectors++; if (out_max !== 4'd12) begin miscompares++; $display("FAIL mixed_max: got %0d expected 12", out_max); end
        vectors++; if (out_min !== 4'd0) begin miscompares++; $display("FAIL mixed_min: got %0d expected 0", out_min); end
        vectors++; if (out_count !== 8'd8) begin miscompares++; $display("FAIL mixed_count: got %0d expected 8", out_count); end
        low = 0;
        while (!in_ready && low < 10) begin
            low++;
            tick();
        end
        vectors++; if (low != 1) begin miscompares++; $display("FAIL mixed_bubble: got %0d low cycles expected 1", low); end
    endtask

    task automatic test_hold_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(4'd1);
        in_valid = 1'b1;
        in_sum   = 4'd5;
        flush    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== 8'd8 || out_count !== 8'd8 ||
                out_max !== 4'd1 || out_min !== 4'd1) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got ready=%0b valid=%0b total=%0d count=%0d max=%0d min=%0d expected 0/1/8/8/1/1",
                         i, in_ready, out_valid, out_total, out_count, out_max, out_min);
            end
            tick();
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        tick();
        vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_total !== 8'd8) begin
            miscompares++;
            $display("FAIL stall_release: got ready=%0b valid=%0b total=%0d expected 1/0/8", in_ready, out_valid, out_total);
        end
        push(4'd5);
        for (int i = 0; i < 7; i++) push(4'd1);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_total !== 8'd12 || out_count !== 8'd8) begin
            miscompares++;
            $display("FAIL stall_next_frame: got valid=%0b total=%0d count=%0d expected 1/12/8", out_valid, out_total, out_count);
        end
        vectors++; if (out_max !== 4'd5 || out_min !== 4'd1) begin miscompares++; $display("FAIL stall_next_maxmin: got max=%0d min=%0d expected 5/1", out_max, out_min); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        push(4'd4);
        push(4'd6);
        flush = 1'b1;
        push(4'd2);
        flush    = 1'b0;
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL flush_valid: got %0b expected 1", out_valid); end
        vectors++; if (out_total !== 8'd12 || out_count !== 8'd3) begin miscompares++; $display("FAIL flush_total_count: got total=%0d count=%0d expected 12/3", out_total, out_count); end
        vectors++; if (out_max !== 4'd6 || out_min !== 4'd2) begin miscompares++; $display("FAIL flush_maxmin: got max=%0d min=%0d expected 6/2", out_max, out_min); end
        tick();
    endtask

    task automatic test_flush_empty();
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL flush_empty_%0d: got valid=%0b ready=%0b expected 0/1", i, out_valid, in_ready);
            end
        end
        flush = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready6 = 1'b1;
        for (int i = 0; i < 8; i++) push6(4'd12);
        in_valid6 = 1'b0;
        vectors++; if (out_valid6 !== 1'b1) begin miscompares++; $display("FAIL sat_valid: got %0b expected 1", out_valid6); end
        vectors++; if (out_total6 !== 6'd63) begin miscompares++; $display("FAIL sat_total: got %0d expected 63", out_total6); end
        vectors++; if (out_sat6 !== 1'b1 || out_count6 !== 8'd8) begin miscompares++; $display("FAIL sat_flag_count: got sat=%0b count=%0d expected 1/8", out_sat6, out_count6); end
        tick();
        for (int i = 0; i < 8; i++) push6(4'd1);
        in_valid6 = 1'b0;
        vectors++; if (out_valid6 !== 1'b1 || out_total6 !== 6'd8 || out_sat6 !== 1'b0) begin
            miscompares++;
            $display("FAIL sat_next_frame: got valid=%0b total=%0d sat=%0b expected 1/8/0", out_valid6, out_total6, out_sat6);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push(4'd3);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ctrl: got valid=%0b ready=%0b expected 0/1", out_valid, in_ready); end
        vectors++; if (out_total !== 8'd0 || out_count !== 8'd0) begin miscompares++; $display("FAIL midrst_data: got total=%0d count=%0d expected 0/0", out_total, out_count); end
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) push(4'd2);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_early_valid: got %0b expected 0", out_valid); end
        push(4'd2);
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_total !== 8'd16 || out_count !== 8'd8) begin
            miscompares++;
            $display("FAIL midrst_frame: got valid=%0b total=%0d count=%0d expected 1/16/8", out_valid, out_total, out_count);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mixed();
        test_hold_stall();
        test_flush();
        test_flush_empty();
        test_saturation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
